hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline sequencing controller for the 5-stage MIPS datapath. It detects RAW register hazards and HI/LO hazards in ID and stalls PC and IF/ID while inserting bubbles into ID/EX. It flushes wrong-path instructions when MEM redirects the PC, and it sequences the multi-cycle multiply/divide unit that writes HI/LO. It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MULDIV_LAT, 4: cycles the HI/LO unit stays busy after a start (legal 1..15).
- CHECK_WB, 1: when 1, ID sources are also compared against the WB destination (register file is not write-through).
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction actually reads rs / rt.
- ID_UsesHiLo  in  1  the ID instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult, multu, div, divu).
- EX_Dst, MEM_Dst, WB_Dst  in  5 each  destination register after the RegDst mux in each stage.
- EX_RegWrite, MEM_RegWrite, WB_RegWrite  in  1 each  the stage's instruction writes the register file.
- EX_MulDiv  in  1  the instruction in EX is a mult or div.
- MEM_Redirect  in  1  branch taken or jump in MEM (PC_Src | MEM_Jump).
- PC_Ld  out  1  PC load enable.
- IFID_Ld  out  1  IF/ID load enable.
- IFID_Clr, IDEX_Clr, EXMEM_Clr  out  1 each  synchronous bubble/flush request; clears the register at the next edge.
- MD_Start  out  1  one-cycle start pulse to the HI/LO unit.
- MD_Busy  out  1  HI/LO unit is computing.
- StallCount, FlushCount  out  CNT_W each  saturating event counters.

## Operation
Hazard terms (combinational):
- raw_rs = ID_UsesRs & ID_Rs≠0 & ((EX_RegWrite & EX_Dst==ID_Rs) | (MEM_RegWrite & MEM_Dst==ID_Rs) | (CHECK_WB & WB_RegWrite & WB_Dst==ID_Rs)).
- raw_rt is the same expression using ID_Rt.
- hilo = ID_UsesHiLo & (EX_MulDiv | MD_Busy).
- stall = (raw_rs | raw_rt | hilo) & ~MEM_Redirect.

Output priority:
- **Redirect** (MEM_Redirect=1): PC_Ld=1, IFID_Ld=1, IFID_Clr=1, IDEX_Clr=1, EXMEM_Clr=1. This flushes the three younger instructions.
- **Else stall**: PC_Ld=0, IFID_Ld=0, IDEX_Clr=1; IFID_Clr=0, EXMEM_Clr=0.
- **Else run**: PC_Ld=1, IFID_Ld=1, all Clr=0.

Multiply/divide FSM, states MD_IDLE and MD_RUN:
- MD_Start = EX_MulDiv & ~MEM_Redirect & (state==MD_IDLE).
- A redirect in the same cycle cancels the start, because that EX instruction is wrong-path.
- MD_IDLE → MD_RUN on MD_Start; md_cnt loads MULDIV_LAT.
- In MD_RUN, md_cnt decrements each cycle. When md_cnt==1, the next state is MD_IDLE and md_cnt becomes 0.
- MD_Busy = (state==MD_RUN).
- A redirect while in MD_RUN does not cancel the operation: the mult is older than the branch.
- EX_MulDiv while in MD_RUN cannot occur, since hilo stalls a second mult in ID. If it does occur, it is ignored.

Counters:
- StallCount += 1 each cycle with stall=1.
- FlushCount += 1 each cycle with MEM_Redirect=1.
- Both saturate at 2^CNT_W−1 and clear only on reset.

## Timing
- Hazard and flush outputs are combinational from the current inputs and state, with zero latency. They act on the next rising edge.
- MD_Start is asserted in the cycle the mult sits in EX. MD_Busy rises on the following edge and stays high for exactly MULDIV_LAT cycles.
- A HI/LO user in ID is released on the first cycle with MD_Busy=0.
- A RAW stall holds until the producer leaves WB (CHECK_WB=1) or MEM (CHECK_WB=0). The maximum is 3 stall cycles.
- Reset (Rst=0, asynchronous): state=MD_IDLE, md_cnt=0, MD_Busy=0, StallCount=0, FlushCount=0.
- With all inputs low during reset: PC_Ld=1, IFID_Ld=1, all Clr=0, MD_Start=0.
- Reset asserted mid-multiply aborts the operation immediately.
- Register $0 never causes a stall.
- Redirect coinciding with a stall: the redirect wins, and StallCount does not increment.

## Test plan
- ID reads $8 (UsesRs=1), EX_Dst=8 with EX_RegWrite=1, CHECK_WB=1, producer advancing each cycle → stall for 3 cycles (PC_Ld=0, IDEX_Clr=1), then run; StallCount=3.
- ID_Rs=0 with EX_Dst=0, EX_RegWrite=1 → no stall; PC_Ld=1.
- EX_MulDiv=1 for one cycle, MULDIV_LAT=4, mflo in ID → MD_Start pulses once, MD_Busy high for 4 cycles. mflo stalls 5 cycles (EX cycle plus 4 busy) and issues in the 6th.
- MEM_Redirect=1 with a RAW hazard in ID and EX_MulDiv=1 → all three Clr=1, PC_Ld=1, MD_Start=0; FlushCount+1, StallCount unchanged.
- Rst driven low during MD_RUN with md_cnt=2, asynchronously (mid-cycle) → MD_Busy=0 immediately; counters read 0.
- CNT_W=4 with 20 consecutive stall cycles → StallCount saturates at 15 and holds.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - datapath <-> hazard control bundle
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       ID_Rs;
   logic [4:0]       ID_Rt;
   logic             ID_UsesRs;
   logic             ID_UsesRt;
   logic             ID_UsesHiLo;
   logic [4:0]       EX_Dst;
   logic [4:0]       MEM_Dst;
   logic [4:0]       WB_Dst;
   logic             EX_RegWrite;
   logic             MEM_RegWrite;
   logic             WB_RegWrite;
   logic             EX_MulDiv;
   logic             MEM_Redirect;
   logic             PC_Ld;
   logic             IFID_Ld;
   logic             IFID_Clr;
   logic             IDEX_Clr;
   logic             EXMEM_Clr;
   logic             MD_Start;
   logic             MD_Busy;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo,
      output EX_Dst, MEM_Dst, WB_Dst, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
      output EX_MulDiv, MEM_Redirect,
      input  PC_Ld, IFID_Ld, IFID_Clr, IDEX_Clr, EXMEM_Clr,
      input  MD_Start, MD_Busy, StallCount, FlushCount
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo,
      input  EX_Dst, MEM_Dst, WB_Dst, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
      input  EX_MulDiv, MEM_Redirect,
      output PC_Ld, IFID_Ld, IFID_Clr, IDEX_Clr, EXMEM_Clr,
      output MD_Start, MD_Busy, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - RAW/HI-LO stall, redirect flush and mul/div sequencing
module hazard_control_unit #(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CHECK_WB   = 1,
   parameter int unsigned CNT_W      = 16
) (
   input logic                  Clk,
   input logic                  Rst,
   hazard_control_unit_if.slave bus
);
   localparam logic [3:0] LP_LAT      = 4'(MULDIV_LAT);
   localparam logic       LP_CHECK_WB = (CHECK_WB != 0);

   typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

   md_state_t        r_state;
   logic [3:0]       r_md_cnt;
   logic             r_md_busy;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_raw_rs;
   logic w_raw_rt;
   logic w_hilo;
   logic w_stall;
   logic w_md_start;

   // WB is compared only when the register file does not forward writes into reads
   assign w_raw_rs = bus.ID_UsesRs & (bus.ID_Rs != 5'd0) &
                     ((bus.EX_RegWrite  & (bus.EX_Dst  == bus.ID_Rs)) |
                      (bus.MEM_RegWrite & (bus.MEM_Dst == bus.ID_Rs)) |
                      (LP_CHECK_WB & bus.WB_RegWrite & (bus.WB_Dst == bus.ID_Rs)));

   assign w_raw_rt = bus.ID_UsesRt & (bus.ID_Rt != 5'd0) &
                     ((bus.EX_RegWrite  & (bus.EX_Dst  == bus.ID_Rt)) |
                      (bus.MEM_RegWrite & (bus.MEM_Dst == bus.ID_Rt)) |
                      (LP_CHECK_WB & bus.WB_RegWrite & (bus.WB_Dst == bus.ID_Rt)));

   assign w_hilo     = bus.ID_UsesHiLo & (bus.EX_MulDiv | r_md_busy);
   assign w_stall    = (w_raw_rs | w_raw_rt | w_hilo) & ~bus.MEM_Redirect;
   assign w_md_start = bus.EX_MulDiv & ~bus.MEM_Redirect & (r_state == MD_IDLE);

   always_comb begin
      bus.PC_Ld     = 1'b1;
      bus.IFID_Ld   = 1'b1;
      bus.IFID_Clr  = 1'b0;
      bus.IDEX_Clr  = 1'b0;
      bus.EXMEM_Clr = 1'b0;
      if (bus.MEM_Redirect) begin
         bus.IFID_Clr  = 1'b1;
         bus.IDEX_Clr  = 1'b1;
         bus.EXMEM_Clr = 1'b1;
      end else if (w_stall) begin
         bus.PC_Ld    = 1'b0;
         bus.IFID_Ld  = 1'b0;
         bus.IDEX_Clr = 1'b1;
      end
   end

   assign bus.MD_Start   = w_md_start;
   assign bus.MD_Busy    = r_md_busy;
   assign bus.StallCount = r_stall_cnt;
   assign bus.FlushCount = r_flush_cnt;

   // A redirect during MD_RUN is ignored: the running op is older than the branch
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= MD_IDLE;
         r_md_cnt  <= 4'd0;
         r_md_busy <= 1'b0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (w_md_start) begin
                  r_state   <= MD_RUN;
                  r_md_cnt  <= LP_LAT;
                  r_md_busy <= 1'b1;
               end
            end
            MD_RUN: begin
               if (r_md_cnt == 4'd1) begin
                  r_state   <= MD_IDLE;
                  r_md_cnt  <= 4'd0;
                  r_md_busy <= 1'b0;
               end else begin
                  r_md_cnt <= r_md_cnt - 4'd1;
               end
            end
            default: begin
               r_state   <= MD_IDLE;
               r_md_cnt  <= 4'd0;
               r_md_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (bus.MEM_Redirect && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed vector bench for hazard_control_unit
module tb_hazard_control_unit;
   logic Clk;
   logic Rst;

   hazard_control_unit_if #(.CNT_W(16)) h  ();
   hazard_control_unit_if #(.CNT_W(4))  h2 ();

   hazard_control_unit #(.MULDIV_LAT(4), .CHECK_WB(1), .CNT_W(16)) u_dut (
      .Clk(Clk), .Rst(Rst), .bus(h.slave)
   );
   hazard_control_unit #(.MULDIV_LAT(4), .CHECK_WB(1), .CNT_W(4)) u_sat (
      .Clk(Clk), .Rst(Rst), .bus(h2.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // expected bits: {PC_Ld, IFID_Ld, IFID_Clr, IDEX_Clr, EXMEM_Clr, MD_Start, MD_Busy}
   typedef struct {
      logic [4:0] rs, rt;
      logic       u_rs, u_rt, u_hl;
      logic [4:0] ex_d, mem_d, wb_d;
      logic       ex_w, mem_w, wb_w, ex_md, redir;
      logic [6:0] exp_o;
   } vec_t;

   localparam logic [6:0] O_RUN   = 7'b1100000;
   localparam logic [6:0] O_STALL = 7'b0001000;
   localparam logic [6:0] O_FLUSH = 7'b1111100;

   vec_t tbl [12];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   exp_stall;
   int   exp_flush;

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic u_rs,
                               input logic u_rt, input logic u_hl, input logic [4:0] ex_d,
                               input logic [4:0] mem_d, input logic [4:0] wb_d, input logic ex_w,
                               input logic mem_w, input logic wb_w, input logic ex_md,
                               input logic redir, input logic [6:0] exp_o);
      vec_t v;
      v.rs = rs; v.rt = rt; v.u_rs = u_rs; v.u_rt = u_rt; v.u_hl = u_hl;
      v.ex_d = ex_d; v.mem_d = mem_d; v.wb_d = wb_d;
      v.ex_w = ex_w; v.mem_w = mem_w; v.wb_w = wb_w; v.ex_md = ex_md; v.redir = redir;
      v.exp_o = exp_o;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      h.ID_Rs = v.rs; h.ID_Rt = v.rt; h.ID_UsesRs = v.u_rs; h.ID_UsesRt = v.u_rt;
      h.ID_UsesHiLo = v.u_hl; h.EX_Dst = v.ex_d; h.MEM_Dst = v.mem_d; h.WB_Dst = v.wb_d;
      h.EX_RegWrite = v.ex_w; h.MEM_RegWrite = v.mem_w; h.WB_RegWrite = v.wb_w;
      h.EX_MulDiv = v.ex_md; h.MEM_Redirect = v.redir;
   endtask

   function automatic logic [6:0] outs();
      return {h.PC_Ld, h.IFID_Ld, h.IFID_Clr, h.IDEX_Clr, h.EXMEM_Clr, h.MD_Start, h.MD_Busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
      h2.ID_Rs = 0; h2.ID_Rt = 0; h2.ID_UsesRs = 0; h2.ID_UsesRt = 0; h2.ID_UsesHiLo = 0;
      h2.EX_Dst = 0; h2.MEM_Dst = 0; h2.WB_Dst = 0; h2.EX_RegWrite = 0; h2.MEM_RegWrite = 0;
      h2.WB_RegWrite = 0; h2.EX_MulDiv = 0; h2.MEM_Redirect = 0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b0;
      idle_inputs();
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   initial begin
      Rst = 1'b0;
      idle_inputs();
      #1;
      chk("reset_outs", 32'(outs()), 32'(O_RUN));
      chk("reset_stallcnt", 32'(h.StallCount), 0);
      chk("reset_flushcnt", 32'(h.FlushCount), 0);

      tbl[0]  = mk(0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, O_RUN);
      tbl[1]  = mk(8,  0, 1, 0, 0, 8,  0, 0,  1, 0, 0, 0, 0, O_STALL);
      tbl[2]  = mk(0,  0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, O_RUN);
      tbl[3]  = mk(0,  9, 0, 1, 0, 0,  9, 0,  0, 1, 0, 0, 0, O_STALL);
      tbl[4]  = mk(0,  9, 0, 0, 0, 0,  9, 0,  0, 1, 0, 0, 0, O_RUN);
      tbl[5]  = mk(10, 0, 1, 0, 0, 0,  0, 10, 0, 0, 1, 0, 0, O_STALL);
      tbl[6]  = mk(10, 0, 1, 0, 0, 10, 0, 0,  0, 0, 0, 0, 0, O_RUN);
      tbl[7]  = mk(8,  0, 1, 0, 1, 8,  0, 0,  1, 0, 0, 1, 1, O_FLUSH);
      tbl[8]  = mk(0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, O_FLUSH);
      tbl[9]  = mk(0,  0, 0, 0, 1, 0,  0, 0,  0, 0, 0, 0, 0, O_RUN);
      tbl[10] = mk(3,  4, 1, 1, 0, 3,  4, 0,  0, 1, 0, 0, 0, O_STALL);
      tbl[11] = mk(5,  0, 1, 0, 0, 6,  0, 0,  1, 0, 0, 0, 0, O_RUN);

      @(negedge Clk);
      Rst = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
      foreach (tbl[i]) begin
         @(negedge Clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp_o));
         if (tbl[i].exp_o[2])                        exp_flush++;
         else if (tbl[i].exp_o[3] && !tbl[i].exp_o[6]) exp_stall++;
      end
      next_cycle();
      chk("tbl_stallcnt", 32'(h.StallCount), 32'(exp_stall));
      chk("tbl_flushcnt", 32'(h.FlushCount), 32'(exp_flush));

      // RAW producer walking EX -> MEM -> WB -> gone
      do_reset();
      drive(mk(8, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0, O_STALL)); #1;
      chk("raw_ex", 32'(outs()), 32'(O_STALL));
      next_cycle();
      drive(mk(8, 0, 1, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, O_STALL)); #1;
      chk("raw_mem", 32'(outs()), 32'(O_STALL));
      next_cycle();
      drive(mk(8, 0, 1, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, O_STALL)); #1;
      chk("raw_wb", 32'(outs()), 32'(O_STALL));
      next_cycle();
      drive(mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN)); #1;
      chk("raw_release", 32'(outs()), 32'(O_RUN));
      next_cycle();
      chk("raw_stallcnt", 32'(h.StallCount), 3);

      // mult in EX with mflo in ID: 5 stall cycles, issue in the 6th
      do_reset();
      drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN)); #1;
      chk("md_c0", 32'(outs()), 32'(O_STALL | 7'b0000010));
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN)); #1;
         chk($sformatf("md_busy_c%0d", c), 32'(outs()), 32'(O_STALL | 7'b0000001));
      end
      next_cycle();
      chk("md_release", 32'(outs()), 32'(O_RUN));
      next_cycle();
      chk("md_stallcnt", 32'(h.StallCount), 5);

      // redirect does not cancel a running op; async reset aborts it mid-cycle
      do_reset();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN)); #1;
      chk("ar_start", 32'(outs()), 32'(O_RUN | 7'b0000010));
      next_cycle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN)); #1;
      chk("ar_redir_busy", 32'(outs()), 32'(O_FLUSH | 7'b0000001));
      next_cycle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN)); #1;
      chk("ar_still_busy", 32'(outs()), 32'(O_RUN | 7'b0000001));
      chk("ar_flushcnt", 32'(h.FlushCount), 1);
      @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      chk("ar_busy_drop", 32'(outs()), 32'(O_RUN));
      chk("ar_flush_clr", 32'(h.FlushCount), 0);
      chk("ar_stall_clr", 32'(h.StallCount), 0);
      @(negedge Clk);
      Rst = 1'b1;

      // 4-bit counter saturation
      do_reset();
      h2.ID_Rs = 5'd8; h2.ID_UsesRs = 1'b1; h2.EX_Dst = 5'd8; h2.EX_RegWrite = 1'b1;
      for (int c = 0; c < 14; c++) next_cycle();
      chk("sat_14", 32'(h2.StallCount), 14);
      for (int c = 0; c < 6; c++) next_cycle();
      chk("sat_hold", 32'(h2.StallCount), 15);
      chk("sat_pcld", 32'(h2.PC_Ld), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
